// File: rtl/parc_rob_param.sv
// ---------------------------------------------------------------------------
// parc_rob_param -- parametrised reorder buffer for the out-of-order PARCv2 core
//
// Slots are allocated in program order at dispatch (at tail), marked complete
// by writeback fills, and retired in order from head once complete and no
// longer speculative. Occupancy is tracked with an explicit counter so all
// DEPTH slots are usable. A mispredicted branch squashes itself and every
// younger entry in one cycle.
//
// Optional feature: define ROB_PERF_EN to build a saturating 32-bit counter
// of cycles in which the ROB is non-empty but the head cannot commit. When
// undefined, perf_stall_cnt is tied to zero and no counter flops exist.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   alloc_val/rdy       dispatch handshake; alloc_preg/alloc_spec describe the
//                       new entry, alloc_slot is the slot granted (tail)
//   fill_val/fill_slot  writeback completion of a slot
//   resolve_*           branch resolution (mispred = 1 squashes)
//   commit_val/slot/preg head entry retirement
//   count/empty/full    occupancy status
//   perf_stall_cnt      head-blocked cycle counter (ROB_PERF_EN)
// ---------------------------------------------------------------------------
module parc_rob_param #(
  parameter int DEPTH  = 16,
  parameter int SLOT_W = 4,
  parameter int PREG_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_val,
  output logic              alloc_rdy,
  input  logic [PREG_W-1:0] alloc_preg,
  input  logic              alloc_spec,
  output logic [SLOT_W-1:0] alloc_slot,
  input  logic              fill_val,
  input  logic [SLOT_W-1:0] fill_slot,
  input  logic              resolve_val,
  input  logic [SLOT_W-1:0] resolve_slot,
  input  logic              resolve_mispred,
  output logic              commit_val,
  output logic [SLOT_W-1:0] commit_slot,
  output logic [PREG_W-1:0] commit_preg,
  output logic [SLOT_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic [31:0]       perf_stall_cnt
);

  // Per-entry state
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  pending_q, pending_d;
  logic [DEPTH-1:0]  spec_q, spec_d;
  logic [PREG_W-1:0] preg_q [DEPTH];

  // Global pointers and occupancy
  logic [SLOT_W-1:0] head_q, head_d;
  logic [SLOT_W-1:0] tail_q, tail_d;
  logic [SLOT_W:0]   count_q, count_d;

  logic              resolve_hit;
  logic              squash;
  logic              resolve_ok;
  logic              alloc_fire;
  logic [SLOT_W-1:0] squash_off;
  logic [DEPTH-1:0]  squash_hit;

  // Resolution only matters for a live speculative entry.
  assign resolve_hit = resolve_val && valid_q[resolve_slot] && spec_q[resolve_slot];
  assign squash      = resolve_hit && resolve_mispred;
  assign resolve_ok  = resolve_hit && !resolve_mispred;

  assign full       = (count_q == (SLOT_W+1)'(DEPTH));
  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign alloc_rdy  = !full && !squash;
  assign alloc_fire = alloc_val && alloc_rdy;
  assign alloc_slot = tail_q;

  // Commit looks only at registered state; suppressed while reset is held so
  // stale entries never retire in the reset cycle.
  assign commit_val  = !reset && valid_q[head_q] && !pending_q[head_q] && !spec_q[head_q];
  assign commit_slot = head_q;
  assign commit_preg = preg_q[head_q];

  // Age of each slot measured from head. Everything at or beyond the branch's
  // age is younger than (or is) the branch. Measuring from head rather than
  // from tail keeps the full case (head == tail) unambiguous.
  assign squash_off = resolve_slot - head_q;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_age
      logic [SLOT_W-1:0] age;
      assign age            = SLOT_W'(gi) - head_q;
      assign squash_hit[gi] = squash && valid_q[gi] && (age >= squash_off);
    end
  endgenerate

  always_comb begin
    valid_d   = valid_q;
    pending_d = pending_q;
    spec_d    = spec_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;

    if (fill_val && valid_q[fill_slot]) begin
      pending_d[fill_slot] = 1'b0;
    end
    if (resolve_ok) begin
      spec_d[resolve_slot] = 1'b0;
    end
    if (commit_val) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end

    if (squash) begin
      // Applied after fill so a same-cycle fill of a squashed slot loses.
      valid_d = valid_d & ~squash_hit;
      tail_d  = resolve_slot;
      count_d = {1'b0, squash_off} - (SLOT_W+1)'(commit_val);
    end else begin
      if (alloc_fire) begin
        tail_d = tail_q + 1'b1;
      end
      count_d = count_q + (SLOT_W+1)'(alloc_fire) - (SLOT_W+1)'(commit_val);
    end

    // The tail slot is never valid when allocation fires, so no conflict with
    // the fill/commit/resolve updates above.
    if (alloc_fire) begin
      valid_d[tail_q]   = 1'b1;
      pending_d[tail_q] = 1'b1;
      spec_d[tail_q]    = alloc_spec;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= '0;
      pending_q <= '0;
      spec_q    <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      valid_q   <= valid_d;
      pending_q <= pending_d;
      spec_q    <= spec_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  // Destination register storage; contents are meaningless while invalid.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      preg_q[tail_q] <= alloc_preg;
    end
  end

`ifdef ROB_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_q <= '0;
    end else if (!empty && !commit_val && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_q;
`else
  assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_parc_rob_param.sv
module tb_parc_rob_param;

  localparam int DEPTH  = 16;
  localparam int SLOT_W = 4;
  localparam int PREG_W = 5;
  localparam int ENT_W  = SLOT_W + PREG_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              alloc_val;
  logic              alloc_rdy;
  logic [PREG_W-1:0] alloc_preg;
  logic              alloc_spec;
  logic [SLOT_W-1:0] alloc_slot;
  logic              fill_val;
  logic [SLOT_W-1:0] fill_slot;
  logic              resolve_val;
  logic [SLOT_W-1:0] resolve_slot;
  logic              resolve_mispred;
  logic              commit_val;
  logic [SLOT_W-1:0] commit_slot;
  logic [PREG_W-1:0] commit_preg;
  logic [SLOT_W:0]   count;
  logic              empty;
  logic              full;
  logic [31:0]       perf_stall_cnt;

  parc_rob_param #(.DEPTH(DEPTH), .SLOT_W(SLOT_W), .PREG_W(PREG_W)) dut (
    .clk(clk), .reset(reset),
    .alloc_val(alloc_val), .alloc_rdy(alloc_rdy), .alloc_preg(alloc_preg),
    .alloc_spec(alloc_spec), .alloc_slot(alloc_slot),
    .fill_val(fill_val), .fill_slot(fill_slot),
    .resolve_val(resolve_val), .resolve_slot(resolve_slot),
    .resolve_mispred(resolve_mispred),
    .commit_val(commit_val), .commit_slot(commit_slot), .commit_preg(commit_preg),
    .count(count), .empty(empty), .full(full), .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  logic [ENT_W-1:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Scoreboard monitor: every commit must match the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && commit_val) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_commit: got slot %0d preg %0d expected no commit",
                 commit_slot, commit_preg);
      end else begin
        logic [ENT_W-1:0] e;
        e = exp_q.pop_front();
        chk("commit_slot", 32'(commit_slot), 32'(e[ENT_W-1:PREG_W]));
        chk("commit_preg", 32'(commit_preg), 32'(e[PREG_W-1:0]));
        $display("commit slot %0d preg %0d", commit_slot, commit_preg);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic alloc(input int preg, input logic spec, input logic push);
    alloc_val  = 1'b1;
    alloc_preg = PREG_W'(preg);
    alloc_spec = spec;
    if (push) exp_q.push_back({alloc_slot, PREG_W'(preg)});
    tick();
    alloc_val  = 1'b0;
    alloc_spec = 1'b0;
  endtask

  task automatic fill(input int slot);
    fill_val  = 1'b1;
    fill_slot = SLOT_W'(slot);
    tick();
    fill_val  = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (!empty && n < 40) begin
      tick();
      n++;
    end
    chk(name, 32'(empty), 32'd1);
  endtask

  initial begin
    int exp_perf;
    reset = 1'b1; alloc_val = 0; alloc_preg = 0; alloc_spec = 0;
    fill_val = 0; fill_slot = 0; resolve_val = 0; resolve_slot = 0; resolve_mispred = 0;

    // Reset state
    do_reset();
    chk("rst_alloc_rdy", 32'(alloc_rdy), 32'd1);
    chk("rst_commit_val", 32'(commit_val), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_perf", perf_stall_cnt, 32'd0);

    // Head pending for 5 cycles
    alloc(5, 1'b0, 1'b0);
    repeat (5) tick();
`ifdef ROB_PERF_EN
    exp_perf = 5;
`else
    exp_perf = 0;
`endif
    chk("perf_stall_5", perf_stall_cnt, 32'(exp_perf));
    // Head becomes committable; reset lands in that very cycle.
    fill(0);
    reset = 1'b1;
    #1;
    chk("reset_no_commit", 32'(commit_val), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_perf", perf_stall_cnt, 32'd0);

    // Fill to full
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      chk("full_alloc_slot", 32'(alloc_slot), 32'(i));
      alloc(i + 1, 1'b0, 1'b1);
    end
    chk("full_full", 32'(full), 32'd1);
    chk("full_alloc_rdy", 32'(alloc_rdy), 32'd0);
    chk("full_count", 32'(count), 32'd16);
    chk("full_commit_val", 32'(commit_val), 32'd0);
    alloc(31, 1'b0, 1'b0);
    chk("full_blocked_count", 32'(count), 32'd16);

    // Out-of-order fill, in-order commit
    fill(2);
    chk("ooo_no_commit_a", 32'(commit_val), 32'd0);
    fill(1);
    chk("ooo_no_commit_b", 32'(commit_val), 32'd0);
    fill(0);
    chk("ooo_commit_val", 32'(commit_val), 32'd1);
    chk("ooo_commit_slot", 32'(commit_slot), 32'd0);
    chk("full_commit_rdy", 32'(alloc_rdy), 32'd0);
    tick();
    chk("after_commit_count", 32'(count), 32'd15);
    chk("after_commit_rdy", 32'(alloc_rdy), 32'd1);
    tick();
    tick();
    chk("ooo_stop_commit", 32'(commit_val), 32'd0);
    chk("ooo_count", 32'(count), 32'd13);
    chk("ooo_head", 32'(commit_slot), 32'd3);

    // Mispredict squash of slots 3..5
    do_reset();
    for (int i = 0; i < 6; i++) alloc(20 + i, (i == 3), 1'b1);
    resolve_val = 1'b1; resolve_slot = 4'd3; resolve_mispred = 1'b1;
    alloc_val = 1'b1; alloc_preg = 5'd9;
    fill_val = 1'b1; fill_slot = 4'd3;
    #1;
    chk("squash_alloc_rdy", 32'(alloc_rdy), 32'd0);
    tick();
    resolve_val = 0; resolve_mispred = 0; alloc_val = 0; fill_val = 0;
    repeat (3) void'(exp_q.pop_back());
    chk("squash_count", 32'(count), 32'd3);
    chk("squash_tail", 32'(alloc_slot), 32'd3);
    alloc(30, 1'b0, 1'b1);
    chk("realloc_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) fill(i);
    wait_empty("squash_drain_empty");
    fill(4);
    fill(5);
    tick();
    chk("squashed_no_commit", 32'(commit_val), 32'd0);
    chk("squashed_count", 32'(count), 32'd0);

    // Correct resolve
    do_reset();
    alloc(7, 1'b1, 1'b1);
    fill(0);
    chk("spec_blocks_commit", 32'(commit_val), 32'd0);
    resolve_val = 1'b1; resolve_slot = 4'd0; resolve_mispred = 1'b0;
    tick();
    resolve_val = 1'b0;
    chk("resolve_commit_val", 32'(commit_val), 32'd1);
    chk("resolve_commit_slot", 32'(commit_slot), 32'd0);
    tick();
    chk("resolve_empty", 32'(empty), 32'd1);

    // Squash at head empties the ROB
    alloc(8, 1'b1, 1'b0);
    alloc(9, 1'b0, 1'b0);
    chk("head_sq_pre_count", 32'(count), 32'd2);
    resolve_val = 1'b1; resolve_slot = 4'd1; resolve_mispred = 1'b1;
    tick();
    resolve_val = 1'b0; resolve_mispred = 1'b0;
    chk("head_sq_count", 32'(count), 32'd0);
    chk("head_sq_empty", 32'(empty), 32'd1);
    chk("head_sq_tail", 32'(alloc_slot), 32'd1);
    chk("head_sq_head", 32'(commit_slot), 32'd1);

    // Wrap with simultaneous allocate and commit
    do_reset();
    for (int i = 0; i < 14; i++) alloc(i + 1, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) fill(i);
    wait_empty("wrap_pre_empty");
    chk("wrap_pre_head", 32'(commit_slot), 32'd14);
    for (int j = 0; j < 4; j++) alloc(16 + j, 1'b0, 1'b1);
    chk("wrap_count4", 32'(count), 32'd4);
    chk("wrap_tail2", 32'(alloc_slot), 32'd2);
    fill(14);
    chk("wrap_commit_val", 32'(commit_val), 32'd1);
    alloc(20, 1'b0, 1'b1);
    chk("wrap_same_count", 32'(count), 32'd4);
    chk("wrap_tail3", 32'(alloc_slot), 32'd3);
    chk("wrap_head15", 32'(commit_slot), 32'd15);
    fill(15); fill(0); fill(1); fill(2);
    wait_empty("wrap_drain_empty");
    tick();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/parc_rob_param.md
Name: parc_rob_param

Overview:
Parametrised reorder buffer for the out-of-order PARCv2 core. It allocates slots in program order at dispatch and marks slots complete on writeback fill. It commits the head entry in order once the entry is complete and non-speculative. Unlike the fixed 16-entry ROB, it tracks occupancy explicitly, so all DEPTH slots are usable. On a mispredicted branch it squashes every entry younger than the branch in a single cycle.

Parameters:
DEPTH, 16, number of entries; power of two, minimum 4
SLOT_W, 4, slot index width; must equal log2(DEPTH)
PREG_W, 5, destination register address width

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
alloc_val  in  1  dispatch requests a slot
alloc_rdy  out  1  slot available this cycle
alloc_preg  in  PREG_W  destination register of the allocating instruction
alloc_spec  in  1  instruction is under an unresolved branch
alloc_slot  out  SLOT_W  slot granted (equals tail)
fill_val  in  1  writeback completes a slot
fill_slot  in  SLOT_W  slot being completed
resolve_val  in  1  branch resolution this cycle
resolve_slot  in  SLOT_W  slot to resolve
resolve_mispred  in  1  1 = mispredict (squash), 0 = correct
commit_val  out  1  head entry commits this cycle
commit_slot  out  SLOT_W  head index
commit_preg  out  PREG_W  head destination register
count  out  SLOT_W+1  occupied entries
empty  out  1  count == 0
full  out  1  count == DEPTH
perf_stall_cnt  out  32  head-blocked cycle counter (see Optional Feature)

Behaviour:
- State per entry: valid, pending, spec, preg. Global state: head, tail (SLOT_W bits, wrap modulo DEPTH) and count.
- Reset: head = tail = 0, count = 0, all valid = 0, all spec = 0. Outputs after reset: alloc_rdy = 1, commit_val = 0, empty = 1, full = 0, perf_stall_cnt = 0.
- alloc_rdy = !full && !resolve_val_squash, where resolve_val_squash = resolve_val && resolve_mispred && the entry is valid and spec.
- Allocation fires when alloc_val && alloc_rdy. Effects at the clock edge: entry[tail] becomes valid = 1, pending = 1, spec = alloc_spec, preg = alloc_preg; tail advances by 1 with wrap.
- Fill: when fill_val and entry[fill_slot] is valid, pending is cleared. A fill to an invalid slot is ignored.
- Resolve acts only when entry[resolve_slot] is both valid and spec; otherwise it is ignored.
  - Correct prediction: spec is cleared.
  - Mispredict: entries from resolve_slot through tail-1 (with wrap), including the branch entry, get valid = 0. tail is set to resolve_slot. count is set to (resolve_slot - head) mod DEPTH, minus 1 if a commit fires in the same cycle.
- Commit: commit_val = valid[head] && !pending[head] && !spec[head]. It is combinational from registered state only, so a fill or resolve in cycle N is visible to commit at cycle N+1. On commit, valid[head] is cleared and head advances by 1.
- Count without a squash: count is incremented by allocation and decremented by commit; a simultaneous allocate and commit leaves it unchanged.
- Full: when count == DEPTH, allocation is blocked; a commit in the same cycle does not free a slot for allocation until the next cycle.
- Empty: commit_val = 0.
- Same-cycle squash and allocation: the squash wins and the allocation is not accepted (alloc_rdy is already 0).
- Squash with resolve_slot == head: the ROB empties, head is unchanged, tail = head, count = 0. No commit can fire that cycle because the head entry is spec.
- Same-cycle fill and squash of the same slot: the squash wins and the entry ends invalid.
- Reset mid-operation discards all entries; no commit_val is asserted in the reset cycle.

Optional Feature:
Macro ROB_PERF_EN.
- Defined: perf_stall_cnt increments each cycle in which the ROB is not empty and commit_val = 0. It saturates at 2^32-1 and clears on reset.
- Undefined: perf_stall_cnt is tied to 0 and no counter flops are synthesised.

Test Plan:
- Fill-to-full: allocate 16 entries with preg 1..16 and no fills. Expect full = 1, alloc_rdy = 0, count = 16, commit_val = 0.
- In-order commit with out-of-order fill: fill slots 2,1,0 on consecutive cycles. Expect commits of slots 0,1,2 starting the cycle after slot 0 is filled, with commit_preg 1,2,3.
- Squash: head = 0, tail = 6, slot 3 spec; resolve slot 3 with mispred = 1. Expect tail = 3, count = 3, slots 3..5 invalid. The next allocation is granted slot 3.
- Correct resolve: slot 0 filled and spec; resolve correct. Expect commit_val = 1 on the next cycle with commit_slot = 0.
- Wrap and simultaneous events: with head = 14 and tail = 2, allocate and commit in the same cycle. Expect count unchanged, tail = 3, head = 15.
- ROB_PERF_EN: hold the head pending for 5 cycles. Expect perf_stall_cnt = 5; with the macro undefined, expect 0.
